// File: rtl/line_fetcher.sv
// Double-buffered video line DMA: a non-pipelined Wishbone read master that copies one
// scanline per HSYNC into alternating line buffers, with per-line stride and VSYNC abort.
module line_fetcher #(
    parameter int AW  = 23,
    parameter int DW  = 16,
    parameter int LBW = 8
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           den_i,
    input  logic           hsync_i,
    input  logic           vsync_i,
    input  logic [AW-1:0]  fb_adr_i,
    input  logic [AW-1:0]  stride_i,
    input  logic [LBW:0]   line_len_i,
    output logic           cyc_o,
    output logic           stb_o,
    output logic [AW-1:0]  adr_o,
    input  logic           ack_i,
    input  logic [DW-1:0]  dat_i,
    output logic           s_we_o,
    output logic [LBW-1:0] s_adr_o,
    output logic [DW-1:0]  s_dat_o,
    output logic           s_buf_o,
    output logic           done_o,
    output logic           ovr_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam logic [LBW:0]   MAX_LEN  = {1'b1, {LBW{1'b0}}};
    localparam logic [LBW:0]   CNT_ONE  = (LBW+1)'(1);
    localparam logic [AW-1:0]  ADR_ONE  = AW'(1);
    localparam logic [LBW-1:0] SADR_ONE = LBW'(1);

    state_t         state_q, state_d;
    logic           hs_q, vs_q;
    logic [AW-1:0]  adr_q, adr_d;
    logic [AW-1:0]  line_ptr_q, line_ptr_d;
    logic [LBW:0]   count_q, count_d;
    logic [LBW-1:0] s_adr_q, s_adr_d;
    logic           s_buf_q, s_buf_d;
    logic           done_q, done_d;
    logic           ovr_q, ovr_d;
    logic           hs_e, vs_e;

    assign hs_e = hsync_i & ~hs_q;
    assign vs_e = vsync_i & ~vs_q;

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        line_ptr_d = line_ptr_q;
        count_d    = count_q;
        s_adr_d    = s_adr_q;
        s_buf_d    = s_buf_q;
        done_d     = 1'b0;
        ovr_d      = 1'b0;

        // VSYNC outranks everything, including a simultaneous HSYNC edge or ack.
        if (vs_e) begin
            line_ptr_d = fb_adr_i;
            adr_d      = fb_adr_i;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs_e && den_i && (line_len_i != '0)) begin
                        state_d    = FETCH;
                        adr_d      = line_ptr_q;
                        s_adr_d    = '0;
                        s_buf_d    = ~s_buf_q;
                        count_d    = (line_len_i > MAX_LEN) ? MAX_LEN : line_len_i;
                        line_ptr_d = line_ptr_q + stride_i;
                    end
                end
                FETCH: begin
                    if (hs_e) begin
                        ovr_d = 1'b1;
                    end
                    if (ack_i) begin
                        adr_d   = adr_q + ADR_ONE;
                        s_adr_d = s_adr_q + SADR_ONE;
                        count_d = count_q - CNT_ONE;
                        if (count_q == CNT_ONE) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            adr_q      <= '0;
            line_ptr_q <= '0;
            count_q    <= '0;
            s_adr_q    <= '0;
            s_buf_q    <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hs_q       <= hsync_i;
            vs_q       <= vsync_i;
            adr_q      <= adr_d;
            line_ptr_q <= line_ptr_d;
            count_q    <= count_d;
            s_adr_q    <= s_adr_d;
            s_buf_q    <= s_buf_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    assign cyc_o   = (state_q == FETCH);
    assign stb_o   = cyc_o;
    assign adr_o   = adr_q;
    assign s_we_o  = cyc_o & ack_i & ~vs_e;
    assign s_adr_o = s_adr_q;
    assign s_dat_o = dat_i;
    assign s_buf_o = s_buf_q;
    assign done_o  = done_q;
    assign ovr_o   = ovr_q;

endmodule
